jt89_gg: RTL and testbench
==========================

Name: jt89_gg

Overview:
- Next-generation SN76489-family PSG core with three tone channels and one noise channel.
- Generalised over the first jt89 with a selectable noise LFSR variant (TI 15-bit or SMS/GG 16-bit), a parametrised prescaler and edge-qualified register writes.
- Adds Game Gear stereo panning, with registered left/right mixes.
- Sits between the CPU bus decode and the audio mixer/DAC stage.

Parameters:
- PRESCALE, 16: clken ticks per tone/noise counter step.
- LFSR_W, 16: noise shift register width (15 = TI, 16 = SMS/GG).
- TAPS, 16'h0009: feedback tap mask for white noise; parity of lfsr & TAPS (TI: 15'h0003).
- MIX_W, 12: width of the signed left/right outputs.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clken  in  1  clock enable; all state advances only when high.
- wr_n  in  1  PSG data port write strobe, active low.
- pan_wr_n  in  1  stereo register write strobe, active low (GG port 0x06).
- din  in  8  write data, shared by both strobes.
- ch0, ch1, ch2  out  10 signed  per-tone-channel output.
- noise  out  10 signed  noise channel output.
- left, right  out  MIX_W signed  panned mixes.

Behaviour:
- Write qualification: each strobe is sampled on clken cycles. A write is taken on the first clken cycle where the strobe is low and was high on the previous clken cycle. Holding a strobe low performs exactly one write. Both strobes may fire in the same cycle; both are applied.
- Latch byte (din[7]=1):
  - Stores the register index din[6:4] in the latch register.
  - Even index: period/ctrl. Odd index: attenuation. Index 6/7: noise.
  - Writes din[3:0] to the low bits of the selected register.
- Data byte (din[7]=0):
  - Writes din[5:0] to period bits [9:4] of the latched tone channel.
  - If the latched index is not a tone period, the byte is ignored.
- Noise control write (index 6): stores din[2:0] and reloads the LFSR with 1<<(LFSR_W-1).
- Prescaler: mod-PRESCALE counter on clken. It emits a one-cycle step pulse when it wraps.
- Tone channel, on each step:
  - The counter decrements. When it reaches 0, it reloads the 10-bit period and toggles the polarity flip-flop.
  - If period ≤ 1, polarity is forced to +1 (DC).
  - A new period takes effect at the next reload, not immediately.
- Noise clock: ctrl[1:0] selects 0/1/2 → internal divider of 16/32/64, or 3 → the ch2 polarity toggle.
  - The LFSR shifts on each rising edge of the noise clock.
  - Feedback is parity(lfsr & TAPS) when ctrl[2]=1 (white), else lfsr[0] (periodic).
  - The new bit enters at MSB. The output bit is lfsr[0].
- Attenuation:
  - 4-bit value, 2 dB steps.
  - Amplitude table: 511,406,322,256,203,161,128,102,81,64,51,40,32,26,20,0.
  - Output = +amp when polarity is 1, −amp when polarity is 0. Value 15 gives 0.
  - Outputs are registered and update 1 clk after the state change.
- Pan register (8 bits):
  - Bit 4+i enables channel i on left; bit i enables channel i on right. Channel 3 is noise.
  - left/right = registered sign-extended sum of enabled channels, 1 clk after channel outputs.
  - No saturation needed: max 4×511 fits 12 bits.
- Reset values:
  - Periods 0.
  - Attenuations 15.
  - Noise ctrl 0; LFSR at seed.
  - Latch index 0; pan 8'hFF.
  - Prescaler 0; polarity 1.
  - All outputs 0.
- Reset mid-operation: asynchronous. All state returns to reset values immediately, and a pending strobe edge is discarded. After reset, the previous-strobe flags read high, so a strobe held low through reset release does not write.
- clken low: state frozen, outputs hold.

Decomposition:
- jt89_gg_pkg:
  - Attenuation amplitude table.
  - Register index constants (TONE0..NOISE_VOL).
  - LFSR seed function.
  - Noise rate encoding.
- Sub-module jt89_gg_tone: 10-bit down counter + polarity flip-flop with step input and DC rule. Instantiated ×3; a fourth instance with a constant period serves as the noise divider.

Test Plan:
- Reset, then wr 8'h8F, 8'h3F (ch0 period 0x3FF), 8'h90 (vol 0):
  - ch0 alternates ±511.
  - Each half-period = 1023×PRESCALE clken cycles.
  - left=right=ch0.
- Period-1 check: wr 8'hA1, 8'h00 (ch1 period 1), 8'hB0 → ch1 constant +511, no toggling.
- Noise: wr 8'hE4 (white, rate /16), 8'hF0 with LFSR_W=16, TAPS=16'h0009 → the first 20 output bits match the golden sequence from the seed 16'h8000.
- Periodic noise: wr 8'hE3 with ch2 period 0x006 → noise toggles at ch2 rate; bit pattern period is 16 shifts.
- Pan:
  - pan_wr 8'h1E with ch0 and ch1 both at +511 → left = ch0 only, right = ch1+ch2+noise.
  - Then hold pan_wr_n low for 10 cycles → only one write occurs.
- Reset mid-tone: assert rst_n low while ch0 is active → all outputs are 0 the same cycle. Release with wr_n held low → no write until wr_n goes high then low.

Source files
------------

// File: rtl/jt89_gg_pkg.sv
// jt89_gg shared definitions: register map, attenuation table, LFSR seed, noise rates.
package jt89_gg_pkg;

    // Register indices carried in din[6:4] of a latch byte
    localparam logic [2:0] IDX_TONE0     = 3'd0;
    localparam logic [2:0] IDX_VOL0      = 3'd1;
    localparam logic [2:0] IDX_TONE1     = 3'd2;
    localparam logic [2:0] IDX_VOL1      = 3'd3;
    localparam logic [2:0] IDX_TONE2     = 3'd4;
    localparam logic [2:0] IDX_VOL2      = 3'd5;
    localparam logic [2:0] IDX_NOISE     = 3'd6;
    localparam logic [2:0] IDX_NOISE_VOL = 3'd7;

    // Noise control bits [1:0]
    typedef enum logic [1:0] {
        NR_16  = 2'd0,
        NR_32  = 2'd1,
        NR_64  = 2'd2,
        NR_CH2 = 2'd3
    } noise_rate_e;

    // 2 dB attenuation steps; 15 is mute
    function automatic logic [8:0] att_amp(input logic [3:0] att);
        case (att)
            4'd0:    return 9'd511;
            4'd1:    return 9'd406;
            4'd2:    return 9'd322;
            4'd3:    return 9'd256;
            4'd4:    return 9'd203;
            4'd5:    return 9'd161;
            4'd6:    return 9'd128;
            4'd7:    return 9'd102;
            4'd8:    return 9'd81;
            4'd9:    return 9'd64;
            4'd10:   return 9'd51;
            4'd11:   return 9'd40;
            4'd12:   return 9'd32;
            4'd13:   return 9'd26;
            4'd14:   return 9'd20;
            default: return 9'd0;
        endcase
    endfunction

    // LFSR starts with only the MSB set (width up to 16)
    function automatic logic [15:0] lfsr_seed(input int w);
        return 16'h1 << (w - 1);
    endfunction

    // Half-period of the internal noise divider for the fixed rates
    function automatic logic [9:0] noise_div(input logic [1:0] rate);
        return 10'd16 << rate;
    endfunction

endpackage

// File: rtl/jt89_gg_tone.sv
// One square-wave generator: 10-bit down counter with polarity flip-flop.
module jt89_gg_tone (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [9:0] period,
    output logic       pol,
    output logic       rise
);
    logic [9:0] cnt_q, cnt_d;
    logic       pol_q, pol_d;

    // Count down on each step; reload and toggle on reaching zero, DC for period <= 1
    always_comb begin
        cnt_d = cnt_q;
        pol_d = pol_q;
        if (step) begin
            if (cnt_q <= 10'd1) begin
                cnt_d = period;
                pol_d = (period <= 10'd1) ? 1'b1 : ~pol_q;
            end else begin
                cnt_d = cnt_q - 10'd1;
            end
        end
    end

    // Counter and polarity registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pol_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            pol_q <= pol_d;
        end
    end

    assign pol  = pol_q;
    assign rise = pol_d & ~pol_q;
endmodule

// File: rtl/jt89_gg.sv
// SN76489-family PSG with selectable LFSR and Game Gear stereo panning.
module jt89_gg
    import jt89_gg_pkg::*;
#(
    parameter int          PRESCALE = 16,
    parameter int          LFSR_W   = 16,
    parameter logic [15:0] TAPS     = 16'h0009,
    parameter int          MIX_W    = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clken,
    input  logic                    wr_n,
    input  logic                    pan_wr_n,
    input  logic [7:0]              din,
    output logic signed [9:0]       ch0,
    output logic signed [9:0]       ch1,
    output logic signed [9:0]       ch2,
    output logic signed [9:0]       noise,
    output logic signed [MIX_W-1:0] left,
    output logic signed [MIX_W-1:0] right
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [LFSR_W-1:0] SEED = LFSR_W'(lfsr_seed(LFSR_W));

    logic [PW-1:0]       pre_q, pre_d;
    logic [2:0][9:0]     per_q, per_d;
    logic [3:0][3:0]     att_q, att_d;
    logic [2:0]          nctl_q, nctl_d;
    logic [2:0]          latch_q, latch_d;
    logic [7:0]          pan_q, pan_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    // "strobe was low at the last clken sample"; set in reset so a held strobe needs a release first
    logic                wr_low_q, wr_low_d, pan_low_q, pan_low_d;
    logic [3:0][9:0]     chan_q, chan_d;
    logic [MIX_W-1:0]    left_q, left_d, right_q, right_d;

    logic                step, wr_take, pan_take, nshift, fb;
    logic [3:0][9:0]     tper;
    logic [3:0]          pol, rise;
    logic                unused;

    assign step = clken && (pre_q == PW'(PRESCALE - 1));
    // Slot 3 is the noise divider, running at a fixed half-period selected by the rate
    assign tper = {noise_div(nctl_q[1:0]), per_q};

    for (genvar g = 0; g < 4; g++) begin : g_tone
        jt89_gg_tone u_tone (
            .clk    (clk),
            .rst_n  (rst_n),
            .step   (step),
            .period (tper[g]),
            .pol    (pol[g]),
            .rise   (rise[g])
        );
    end
    assign unused = ^{pol[3], rise[1:0]};

    assign nshift = (noise_rate_e'(nctl_q[1:0]) == NR_CH2) ? rise[2] : rise[3];
    assign fb     = nctl_q[2] ? ^(lfsr_q & TAPS[LFSR_W-1:0]) : lfsr_q[0];

    // Register file, strobe edge qualification, prescaler and LFSR
    always_comb begin
        pre_d     = pre_q;
        per_d     = per_q;
        att_d     = att_q;
        nctl_d    = nctl_q;
        latch_d   = latch_q;
        pan_d     = pan_q;
        lfsr_d    = lfsr_q;
        wr_low_d  = wr_low_q;
        pan_low_d = pan_low_q;
        wr_take   = 1'b0;
        pan_take  = 1'b0;
        if (clken) begin
            pre_d     = (pre_q == PW'(PRESCALE - 1)) ? '0 : pre_q + PW'(1);
            wr_take   = ~wr_n & ~wr_low_q;
            pan_take  = ~pan_wr_n & ~pan_low_q;
            wr_low_d  = ~wr_n;
            pan_low_d = ~pan_wr_n;
            if (nshift) lfsr_d = {fb, lfsr_q[LFSR_W-1:1]};
            if (pan_take) pan_d = din;
            if (wr_take) begin
                if (din[7]) begin
                    latch_d = din[6:4];
                    if (din[6:4] == IDX_NOISE) begin
                        nctl_d = din[2:0];
                        lfsr_d = SEED;
                    end else if (din[4]) begin
                        att_d[din[6:5]] = din[3:0];
                    end else begin
                        per_d[din[6:5]][3:0] = din[3:0];
                    end
                end else if (!latch_q[0] && latch_q != IDX_NOISE) begin
                    // data bytes only extend a latched tone period
                    per_d[latch_q[2:1]][9:4] = din[5:0];
                end
            end
        end
    end

    // Signed channel levels and panned sums
    always_comb begin
        left_d  = '0;
        right_d = '0;
        for (int i = 0; i < 4; i++) begin
            logic pos;
            logic [9:0] amp;
            pos = (i == 3) ? lfsr_q[0] : pol[i];
            amp = {1'b0, att_amp(att_q[i])};
            chan_d[i] = pos ? amp : 10'd0 - amp;
            if (pan_q[4+i]) left_d  = left_d  + {{(MIX_W-10){chan_q[i][9]}}, chan_q[i]};
            if (pan_q[i])   right_d = right_d + {{(MIX_W-10){chan_q[i][9]}}, chan_q[i]};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            per_q     <= '0;
            att_q     <= '1;
            nctl_q    <= '0;
            latch_q   <= IDX_TONE0;
            pan_q     <= 8'hFF;
            lfsr_q    <= SEED;
            wr_low_q  <= 1'b1;
            pan_low_q <= 1'b1;
            chan_q    <= '0;
            left_q    <= '0;
            right_q   <= '0;
        end else begin
            pre_q     <= pre_d;
            per_q     <= per_d;
            att_q     <= att_d;
            nctl_q    <= nctl_d;
            latch_q   <= latch_d;
            pan_q     <= pan_d;
            lfsr_q    <= lfsr_d;
            wr_low_q  <= wr_low_d;
            pan_low_q <= pan_low_d;
            chan_q    <= chan_d;
            left_q    <= left_d;
            right_q   <= right_d;
        end
    end

    assign ch0   = $signed(chan_q[0]);
    assign ch1   = $signed(chan_q[1]);
    assign ch2   = $signed(chan_q[2]);
    assign noise = $signed(chan_q[3]);
    assign left  = $signed(left_q);
    assign right = $signed(right_q);
endmodule

// File: tb/tb_jt89_gg.sv
// Bench for jt89_gg: behavioural model compared every cycle, plus directed literal checks.
module tb_jt89_gg;
    localparam int P = 4;

    logic clk = 1'b0, rst_n = 1'b0, clken = 1'b0, wr_n = 1'b1, pan_wr_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic signed [9:0]  ch0, ch1, ch2, noise;
    logic signed [11:0] left, right;

    jt89_gg #(.PRESCALE(P), .LFSR_W(16), .TAPS(16'h0009), .MIX_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .clken(clken), .wr_n(wr_n), .pan_wr_n(pan_wr_n),
        .din(din), .ch0(ch0), .ch1(ch1), .ch2(ch2), .noise(noise),
        .left(left), .right(right)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit chk_on = 0;
    int AMP[16] = '{511, 406, 322, 256, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 0};

    // ---- behavioural model ----
    int m_pre, m_cnt[4], m_per[3], m_att[4], m_nctl, m_latch, m_pan, m_lfsr, m_shifts;
    bit m_pol[4], m_wr_hi, m_pan_hi;
    int e_ch[4], e_l, e_r;
    bit [19:0] m_bits;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pre = 0; m_nctl = 0; m_latch = 0; m_pan = 'hFF; m_lfsr = 'h8000;
        m_shifts = 0; m_bits = '0; m_wr_hi = 0; m_pan_hi = 0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_pol[i] = 1; m_att[i] = 15; e_ch[i] = 0;
        end
        for (int i = 0; i < 3; i++) m_per[i] = 0;
        e_l = 0; e_r = 0;
    endtask

    // a square wave: half-period = period steps, period <= 1 holds high
    task automatic m_tone(input int i, input int per, output bit rose);
        bit old;
        old = m_pol[i];
        rose = 0;
        if (m_cnt[i] <= 1) begin
            m_cnt[i] = per;
            m_pol[i] = (per <= 1) ? 1'b1 : !m_pol[i];
        end else m_cnt[i]--;
        rose = !old && m_pol[i];
    endtask

    task automatic m_clock();
        bit r[4];
        bit wr_edge, pan_edge, shift;
        int fbit;
        e_l = 0; e_r = 0;
        for (int i = 0; i < 4; i++) begin
            if ((m_pan >> (4 + i)) & 1) e_l += e_ch[i];
            if ((m_pan >> i) & 1)       e_r += e_ch[i];
        end
        for (int i = 0; i < 3; i++) e_ch[i] = m_pol[i] ? AMP[m_att[i]] : -AMP[m_att[i]];
        e_ch[3] = (m_lfsr & 1) ? AMP[m_att[3]] : -AMP[m_att[3]];
        if (!clken) return;
        for (int i = 0; i < 4; i++) r[i] = 0;
        if (m_pre == P - 1) begin
            for (int i = 0; i < 4; i++)
                m_tone(i, (i < 3) ? m_per[i] : (16 << (m_nctl & 3)), r[i]);
        end
        m_pre = (m_pre + 1) % P;
        shift = ((m_nctl & 3) == 3) ? r[2] : r[3];
        if (shift) begin
            fbit = (m_nctl & 4) ? ($countones(m_lfsr & 'h0009) & 1) : (m_lfsr & 1);
            m_lfsr = (m_lfsr >> 1) | (fbit << 15);
            m_shifts++;
            if (m_shifts <= 20) m_bits[m_shifts-1] = m_lfsr[0];
        end
        wr_edge  = !wr_n && m_wr_hi;
        pan_edge = !pan_wr_n && m_pan_hi;
        m_wr_hi  = wr_n;
        m_pan_hi = pan_wr_n;
        if (pan_edge) m_pan = din;
        if (wr_edge) begin
            if (din[7]) begin
                m_latch = din[6:4];
                if (m_latch == 6) begin
                    m_nctl = din[2:0]; m_lfsr = 'h8000; m_shifts = 0; m_bits = '0;
                end else if (m_latch % 2 == 1) m_att[m_latch/2] = din[3:0];
                else m_per[m_latch/2] = (m_per[m_latch/2] & 'h3F0) | din[3:0];
            end else if (m_latch == 0 || m_latch == 2 || m_latch == 4) begin
                m_per[m_latch/2] = (m_per[m_latch/2] & 'hF) | (din[5:0] << 4);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else m_clock();
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("ch0", ch0, e_ch[0]);
            check("ch1", ch1, e_ch[1]);
            check("ch2", ch2, e_ch[2]);
            check("noise", noise, e_ch[3]);
            check("left", left, e_l);
            check("right", right, e_r);
        end
    end

    // ---- stimulus ----
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] b);
        din = b; wr_n = 1'b0; tick();
        wr_n = 1'b1; tick();
    endtask

    initial begin
        int last_sgn, nchg, nbad;
        int tchg[2];
        m_reset();
        clken = 1'b1;
        tick(); tick();
        chk_on = 1;
        check("rst_ch0", ch0, 0);
        check("rst_left", left, 0);
        rst_n = 1'b1;
        tick(); tick();
        check("rst_noise", noise, 0);

        // full-scale square on ch0
        wr(8'h8F); wr(8'h3F); wr(8'h90);
        last_sgn = 0; nchg = 0; tchg[0] = 0; tchg[1] = 0;
        for (int t = 0; t < 10000 && nchg < 2; t++) begin
            tick();
            if (ch0 != 0) begin
                if (last_sgn != 0 && ((ch0 > 0) ? 1 : -1) != last_sgn) begin
                    tchg[nchg] = t; nchg++;
                end
                last_sgn = (ch0 > 0) ? 1 : -1;
            end
        end
        check("ch0_toggles", nchg, 2);
        check("ch0_halfper", tchg[1] - tchg[0], 1023 * P);
        check("ch0_mag", (ch0 < 0) ? -ch0 : ch0, 511);
        check("left_mag", (left < 0) ? -left : left, 511);

        // period 1 holds DC
        wr(8'hA1); wr(8'h00); wr(8'hB0);
        tick(); tick();
        nbad = 0;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (ch1 != 511) nbad++;
        end
        check("ch1_dc_cycles", nbad, 0);

        // white noise from the seed
        wr(8'hE4); wr(8'hF0);
        for (int t = 0; t < 5000 && m_shifts < 20; t++) tick();
        check("white_shifts", m_shifts, 20);
        check("white_bits", m_bits, 20'h04000);
        check("white_lfsr20", m_lfsr, 'h0900);

        // periodic noise clocked by ch2
        wr(8'hC6); wr(8'h00); wr(8'hE3);
        for (int t = 0; t < 3000 && m_shifts < 16; t++) tick();
        check("per_shifts", m_shifts, 16);
        check("per_bits", m_bits[15:0], 16'h4000);
        check("per_lfsr16", m_lfsr, 'h8000);

        // panning with ch0/ch1 at +511, ch2 at 322, noise muted
        wr(8'h81); wr(8'h00); wr(8'h90);
        wr(8'hC0); wr(8'h00); wr(8'hD2); wr(8'hFF);
        din = 8'h1E; pan_wr_n = 1'b0; tick(); pan_wr_n = 1'b1;
        repeat (4200) tick();
        check("pan_left", left, 511);
        check("pan_right", right, 833);
        din = 8'h1E; pan_wr_n = 1'b1; tick();
        pan_wr_n = 1'b0; tick();
        din = 8'hF0;
        repeat (9) tick();
        pan_wr_n = 1'b1;
        repeat (4) tick();
        check("pan_hold_left", left, 511);
        check("pan_hold_right", right, 833);

        // reset in the middle of a tone, strobe held through release
        wr(8'h84); wr(8'h00);
        repeat (200) tick();
        din = 8'h90; wr_n = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_ch0", ch0, 0);
        check("midrst_left", left, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("held_no_write", ch0, 0);
        wr_n = 1'b1; tick();
        wr_n = 1'b0; tick();
        wr_n = 1'b1;
        repeat (3) tick();
        check("rewrite_ch0", ch0, 511);
        check("rewrite_left", left, 511);

        // randomized traffic with clken gaps
        for (int k = 0; k < 4000; k++) begin
            clken = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) wr_n = ~wr_n;
            if ($urandom_range(0, 15) == 0) pan_wr_n = ~pan_wr_n;
            if ($urandom_range(0, 3) == 0) begin
                din = 8'($urandom);
                if (!din[7] && $urandom_range(0, 1) == 0) din = din & 8'h03;
            end
            if (k == 2500) rst_n = 1'b0;
            if (k == 2503) rst_n = 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
